// File: rtl/ps2_tx_if.sv
// PS/2 host-transmitter bus bundle: command strobe/byte, pad read-back,
// open-drain pad enables and transfer status.
interface ps2_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c;
  logic       ps2d;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err;

  // Command source / pad side
  modport master (
    output wr_ps2, din, ps2c, ps2d,
    input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err
  );

  // Transmitter side
  modport slave (
    input  wr_ps2, din, ps2c, ps2d,
    output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err
  );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. Performs request-to-send (clock held low,
// then start bit), shifts 8 data bits LSB first, odd parity and stop on the
// device's falling clock edges, and reports completion or timeout.
// Optional feature macro: PS2_TX_ACK_EN -- when defined, the device ack bit
// is checked on edge 11 and completion waits for both lines to float high.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic     clk,
  input  logic     reset,
  ps2_tx_if.slave  bus
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RTS   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef PS2_TX_ACK_EN
  localparam logic [2:0] S_ACKW  = 3'd5;
`endif

  // Clock line conditioning
  logic             c_meta_q, c_sync_q;
  logic             fc_q, fc_d;
  logic [FLT_W-1:0] fc_cnt_q, fc_cnt_d;
  logic             fall;

  // Transmit FSM state
  logic [2:0]       state_q, state_d;
  logic [8:0]       sr_q, sr_d;
  logic [3:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             idle_q, idle_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout;

  // ps2c agreement filter: follow the synchronised pin only after
  // FILTER_LEN consecutive disagreeing samples
  always_comb begin
    fc_d     = fc_q;
    fc_cnt_d = '0;
    if (c_sync_q != fc_q) begin
      if (fc_cnt_q == FLT_LAST) fc_d = c_sync_q;
      else                      fc_cnt_d = fc_cnt_q + 1'b1;
    end
  end

  assign fall = fc_q & ~fc_d;

  // ps2c synchroniser and filter registers; idle line level is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      fc_q     <= 1'b1;
      fc_cnt_q <= '0;
    end else begin
      c_meta_q <= bus.ps2c;
      c_sync_q <= c_meta_q;
      fc_q     <= fc_d;
      fc_cnt_q <= fc_cnt_d;
    end
  end

`ifdef PS2_TX_ACK_EN
  logic             d_meta_q, d_sync_q;
  logic             fd_q, fd_d;
  logic [FLT_W-1:0] fd_cnt_q, fd_cnt_d;

  // ps2d agreement filter, same rule as the clock line
  always_comb begin
    fd_d     = fd_q;
    fd_cnt_d = '0;
    if (d_sync_q != fd_q) begin
      if (fd_cnt_q == FLT_LAST) fd_d = d_sync_q;
      else                      fd_cnt_d = fd_cnt_q + 1'b1;
    end
  end

  // ps2d synchroniser and filter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      fd_q     <= 1'b1;
      fd_cnt_q <= '0;
    end else begin
      d_meta_q <= bus.ps2d;
      d_sync_q <= d_meta_q;
      fd_q     <= fd_d;
      fd_cnt_q <= fd_cnt_d;
    end
  end
`endif

  // Transmit sequencing: RTS countdown, bit shifting on device clock falls,
  // and a watchdog that reloads on every fall once the device owns the clock
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    c_oe_d  = c_oe_q;
    d_oe_d  = d_oe_q;
    idle_d  = idle_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    timeout = 1'b0;

    // A fall in the expiry cycle keeps the transfer alive
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP
`ifdef PS2_TX_ACK_EN
        || state_q == S_ACKW
`endif
       ) begin
      if (fall)                 cnt_d   = '0;
      else if (cnt_q == TO_LAST) timeout = 1'b1;
      else                      cnt_d   = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        idle_d = 1'b1;
        if (bus.wr_ps2) begin
          sr_d    = {~^bus.din, bus.din};
          cnt_d   = INH_LAST;
          c_oe_d  = 1'b1;
          idle_d  = 1'b0;
          state_d = S_RTS;
        end
      end
      S_RTS: begin
        if (cnt_q == '0) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_START: begin
        if (fall) begin
          d_oe_d  = ~sr_q[0];
          sr_d    = {1'b0, sr_q[8:1]};
          n_d     = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          if (n_q == 4'd8) begin
            d_oe_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            d_oe_d = ~sr_q[0];
            sr_d   = {1'b0, sr_q[8:1]};
            n_d    = n_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (fall) begin
`ifdef PS2_TX_ACK_EN
          if (!fd_q) begin
            state_d = S_ACKW;
          end else begin
            state_d = S_IDLE;
            idle_d  = 1'b1;
            err_d   = 1'b1;
          end
`else
          state_d = S_IDLE;
          idle_d  = 1'b1;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PS2_TX_ACK_EN
      S_ACKW: begin
        if (fc_q && fd_q) begin
          state_d = S_IDLE;
          idle_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        idle_d  = 1'b1;
      end
    endcase

    // Watchdog expiry releases both lines and aborts the transfer
    if (timeout) begin
      state_d = S_IDLE;
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      idle_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b1;
      cnt_d   = '0;
    end
  end

  // FSM and registered outputs; reset releases both pads asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ps2c_oe      = c_oe_q;
  assign bus.ps2d_oe      = d_oe_q;
  assign bus.tx_idle      = idle_q;
  assign bus.tx_done_tick = done_q;
  assign bus.tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx: open-drain pads are modelled as wired-AND of the
// transmitter enables and a behavioural PS/2 device that clocks the frame,
// samples data on its rising clock edges and optionally drives the ack bit.
module tb_ps2_tx;

  localparam int INH = 100;
  localparam int FLT = 4;
  localparam int TO  = 5000;
`ifdef PS2_TX_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic dev_c = 1'b1;
  logic dev_d = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int bad_pulse = 0;
  int both_oe = 0;

  ps2_tx_if bus();

  assign bus.ps2c = dev_c & ~bus.ps2c_oe;
  assign bus.ps2d = dev_d & ~bus.ps2d_oe;

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_done_tick) done_cnt <= done_cnt + 1;
    if (bus.tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if ((bus.tx_done_tick || bus.tx_err) && !bus.tx_idle) bad_pulse <= bad_pulse + 1;
    if (bus.ps2c_oe && bus.ps2d_oe) both_oe <= both_oe + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
  endtask

  // Device side of one frame: measure the inhibit, record the start bit,
  // then generate n_edges clock pulses (1000-cycle period).
  task automatic dev_frame(input int n_edges, input bit give_ack, input bit inject,
                           output logic [10:0] bits, output int lo_cyc, output int last_fall);
    int lo;
    bits = '0;
    lo = 0;
    last_fall = cyc;
    while (bus.ps2c == 1'b0 && lo < 1000) begin
      lo++;
      @(negedge clk);
    end
    lo_cyc = lo;
    bits[0] = bus.ps2d;
    repeat (200) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_c = 1'b0;
      last_fall = cyc;
      for (int t = 0; t < 500; t++) begin
        if (inject && e == 3 && t == 100) begin
          bus.wr_ps2 = 1'b1;
          bus.din    = ~bus.din;
        end else begin
          bus.wr_ps2 = 1'b0;
        end
        @(negedge clk);
      end
      dev_c = 1'b1;
      if (e <= 10) bits[e] = bus.ps2d;
      if (e == 10 && give_ack) dev_d = 1'b0;
      repeat (500) @(negedge clk);
      if (e == 11) dev_d = 1'b1;
    end
    dev_c = 1'b1;
    dev_d = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && !bus.tx_idle; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({nm, ":idle_end"}, bus.tx_idle, 1);
  endtask

  task automatic strobe(input logic [7:0] d, input string nm);
    bus.din    = d;
    bus.wr_ps2 = 1'b1;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    check({nm, ":c_oe_k1"}, bus.ps2c_oe, 1);
    check({nm, ":idle_k1"}, bus.tx_idle, 0);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit give_ack, input bit inject, input string nm);
    logic [10:0] bits;
    logic [10:0] exp_bits;
    int lo, lf, d0, e0, ones, dev_ones;
    bit par, want_err;
    d0 = done_cnt;
    e0 = err_cnt;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'((d >> i) & 8'd1);
    par = (ones % 2 == 0);
    exp_bits = {1'b1, par, d, 1'b0};
    want_err = ACK_EN && !give_ack;
    strobe(d, nm);
    dev_frame(11, give_ack, inject, bits, lo, lf);
    wait_idle(nm);
    check({nm, ":rts_len"}, lo, INH);
    check({nm, ":frame"}, bits, exp_bits);
    dev_ones = 0;
    for (int i = 1; i <= 9; i++) dev_ones += int'(bits[i]);
    check({nm, ":odd_par"}, dev_ones % 2, 1);
    check({nm, ":done"}, done_cnt - d0, want_err ? 0 : 1);
    check({nm, ":err"}, err_cnt - e0, want_err ? 1 : 0);
    check({nm, ":oe_rel"}, {bus.ps2c_oe, bus.ps2d_oe}, 0);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL global_timeout: got %0d cycles, want finish", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [10:0] bits;
    int lo, lf, d0, e0, delta;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst:c_oe", bus.ps2c_oe, 0);
    check("rst:d_oe", bus.ps2d_oe, 0);
    check("rst:idle", bus.tx_idle, 1);
    check("rst:done", bus.tx_done_tick, 0);
    check("rst:err", bus.tx_err, 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("quiet:idle", bus.tx_idle, 1);
    check("quiet:c_oe", bus.ps2c_oe, 0);
    check("quiet:pulses", done_cnt + err_cnt, 0);

    // Known commands and parity corner cases
    run_frame(8'hED, 1'b1, 1'b0, "ed");
    run_frame(8'h01, 1'b1, 1'b0, "x01");
    run_frame(8'hFF, 1'b1, 1'b0, "xff");

    // Reset while the data phase is driving the line low
    d0 = done_cnt;
    e0 = err_cnt;
    strobe(8'h00, "rstmid");
    dev_frame(4, 1'b0, 1'b0, bits, lo, lf);
    check("rstmid:d_oe_before", bus.ps2d_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid:c_oe", bus.ps2c_oe, 0);
    check("rstmid:d_oe", bus.ps2d_oe, 0);
    check("rstmid:idle", bus.tx_idle, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rstmid:no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    check("rstmid:idle_after", bus.tx_idle, 1);

    // Random byte with a stray strobe and din change mid-frame
    run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, "rnd_inj");

    // Device stops clocking after four edges
    d0 = done_cnt;
    e0 = err_cnt;
    strobe(8'($urandom_range(0, 255)), "tmo");
    dev_frame(4, 1'b0, 1'b0, bits, lo, lf);
    for (int i = 0; i < 8000 && err_cnt == e0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    delta = err_cyc - lf;
    check("tmo:err", err_cnt - e0, 1);
    check("tmo:done", done_cnt - d0, 0);
    check("tmo:window", (delta >= TO && delta <= TO + 30) ? 1 : 0, 1);
    check("tmo:idle", bus.tx_idle, 1);
    check("tmo:oe", {bus.ps2c_oe, bus.ps2d_oe}, 0);

    // Device withholds the ack bit
    run_frame(8'hF4, 1'b0, 1'b0, "noack");

    check("pulse_idle", bad_pulse, 0);
    check("both_oe", both_oe, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain ps2c/ps2d lines the PS/2 receiver listens on. It performs the request-to-send sequence, shifts out start, 8 data bits LSB first, odd parity and stop on device-generated clock edges, and reports completion. `tx_idle` drives the receiver's `rx_en` so the receiver ignores the bus while a command is in flight.

## Interface
- `INHIBIT_CYCLES`, 10000 — clk cycles ps2c is held low for request-to-send (100 µs at 100 MHz).
- `FILTER_LEN`, 8 — consecutive equal samples required before the filtered line value changes.
- `TIMEOUT_CYCLES`, 2000000 — max clk cycles between device clock falling edges before abort (20 ms).
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `wr_ps2` in 1 — one-cycle start strobe; accepted only when `tx_idle`=1.
- `din` in 8 — command byte, captured on accepted `wr_ps2`.
- `ps2c` in 1 — PS/2 clock pin value (read back from the pad).
- `ps2d` in 1 — PS/2 data pin value.
- `ps2c_oe` out 1 — 1 = drive ps2c pad low; 0 = release (pull-up high).
- `ps2d_oe` out 1 — 1 = drive ps2d pad low; 0 = release.
- `tx_idle` out 1 — 1 when no transfer in progress.
- `tx_done_tick` out 1 — one-cycle pulse on successful completion.
- `tx_err` out 1 — one-cycle pulse on timeout (or missing ack, see Configuration).

## Operation
- Input conditioning: ps2c/ps2d each pass a 2-FF synchroniser, then a FILTER_LEN-sample agreement filter (filtered value resets to 1). `fall` = filtered ps2c 1→0, one-cycle tick.
- Shift register `sr[8:0]` = {parity, din}, parity = ~^din (odd). Bit counter `n` 4 bits.
- States:
  - IDLE: both oe=0, `tx_idle`=1. On `wr_ps2`: load sr, counter=INHIBIT_CYCLES-1, → RTS.
  - RTS: `ps2c_oe`=1. Counter decrements; at 0: `ps2d_oe`=1 (start bit), → START.
  - START: `ps2c_oe`=0, `ps2d_oe`=1. On `fall`: `ps2d_oe`=~sr[0], shift sr right, n=0, → DATA.
  - DATA: on `fall`: if n<8: `ps2d_oe`=~sr[0], shift, n=n+1; if n==8: `ps2d_oe`=0 (stop bit), → STOP. Edges 2–9 of the frame carry d1..d7, parity.
  - STOP: on `fall` (edge 11): → DONE handling per Configuration.
- Watchdog: in START/DATA/STOP a counter reloads on every `fall`; reaching TIMEOUT_CYCLES → both oe=0, `tx_err`=1 for one cycle, → IDLE.
- `wr_ps2` while `tx_idle`=0 is ignored; `din` changes after capture have no effect.
- Outputs are registered; oe outputs never glitch.

## Timing
- Reset values: `ps2c_oe`=0, `ps2d_oe`=0, `tx_idle`=1, `tx_done_tick`=0, `tx_err`=0; state IDLE, sr=0, counters 0.
- `wr_ps2` at cycle k → `ps2c_oe`=1 and `tx_idle`=0 at k+1; `ps2d_oe`=1 at k+INHIBIT_CYCLES+1; `ps2c_oe`=0 same cycle.
- Pad falling edge → `fall` tick 2+FILTER_LEN cycles later → `ps2d_oe` updates next cycle.
- `tx_done_tick`/`tx_err` assert in the cycle `tx_idle` returns to 1.
- Reset asserted mid-transfer: both lines released immediately (asynchronously), no done/err pulse.
- `fall` and watchdog expiry in the same cycle: `fall` wins.

## Configuration
- `PS2_TX_ACK_EN` defined: in STOP, on edge 11 sample filtered ps2d; low → wait until filtered ps2c and ps2d both high, then `tx_done_tick`; high → `tx_err`. Watchdog still applies while waiting.
- Undefined: edge 11 → `tx_done_tick` unconditionally, no ack check, immediately IDLE.

## Test plan
(Bench uses INHIBIT_CYCLES=100, FILTER_LEN=4, TIMEOUT_CYCLES=5000; device model clocks at 1000-cycle period.)
- Reset: hold `reset`=0 → all outputs at reset values; release, no activity → `tx_idle` stays 1.
- `din`=0xED → ps2c low exactly 100 cycles, then bits sampled on device rising edges = 0,1,0,1,1,0,1,1,1,1(parity),1(stop); `tx_done_tick` once.
- `din`=0x01 → parity 0, `din`=0xFF → parity 1; device model checks odd parity, both pass.
- Device stops clocking after 4 edges → `tx_err` pulse ~5000 cycles after last edge, both oe=0, `tx_idle`=1.
- `PS2_TX_ACK_EN` on, device withholds ack → `tx_err`, no `tx_done_tick`; with ack → `tx_done_tick` after lines return high.
- Reset pulsed during DATA, second `wr_ps2` during transfer → lines released at once; extra strobe ignored, frame unchanged.
